// File: rtl/crc_frame_seq.sv
// CRC frame sequencer: buffers a frame, bursts it gap-free into the CRC engine, replays it plus a CRC beat; first m_valid N+3 cycles after s_last.
// m_ready stalls hold m_data; s_ready is low from CALC to CRCW. Define CRC_FINAL_XOR_EN to complement the appended CRC.
module crc_frame_seq #(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic        m_last,
    output logic        crc_din_valid,
    output logic [31:0] crc_din,
    input  logic        crc_dout_valid,
    input  logic [31:0] crc_dout,
    output logic        ovf_err,
    output logic        busy
);
    localparam logic [ADDR_W:0]   FULL  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {IDLE, FILL, FLUSH, CALC, CAPT, DRAIN, CRCW} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W:0]   wr_cnt, wr_cnt_nxt, rd_cnt, rd_cnt_nxt;
    logic [31:0]       mem [2**ADDR_W];
    logic [31:0]       ram_q, crc_reg, crc_out;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we, ram_re, s_acc, m_acc, cdv_nxt, ovf_nxt;

`ifdef CRC_FINAL_XOR_EN
    assign crc_out = ~crc_reg;
`else
    assign crc_out = crc_reg;
`endif

    assign s_ready = !rst && (state == IDLE || state == FILL || state == FLUSH);
    assign m_valid = (state == DRAIN) || (state == CRCW);
    assign m_last  = (state == CRCW);
    assign m_data  = (state == DRAIN) ? ram_q : ((state == CRCW) ? crc_out : '0);
    assign busy    = (state != IDLE);
    assign s_acc   = s_valid && s_ready;
    assign m_acc   = m_valid && m_ready;
    assign crc_din = crc_din_valid ? ram_q : '0;

    always_comb begin
        state_nxt  = state;
        wr_cnt_nxt = wr_cnt;
        rd_cnt_nxt = rd_cnt;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = rd_cnt[ADDR_W-1:0];
        cdv_nxt    = 1'b0;
        ovf_nxt    = 1'b0;
        case (state)
            IDLE: if (s_acc) begin
                ram_we     = 1'b1;
                ram_addr   = '0;
                wr_cnt_nxt = ONE;
                state_nxt  = s_last ? CALC : FILL;
            end
            FILL: if (s_acc) begin
                if (wr_cnt == FULL) begin
                    // Word that does not fit is dropped along with the rest of the frame.
                    wr_cnt_nxt = '0;
                    if (s_last) begin
                        ovf_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = FLUSH;
                    end
                end else begin
                    ram_we     = 1'b1;
                    ram_addr   = wr_cnt[ADDR_W-1:0];
                    wr_cnt_nxt = wr_cnt + ONE;
                    if (s_last) state_nxt = CALC;
                end
            end
            FLUSH: if (s_acc && s_last) begin
                ovf_nxt   = 1'b1;
                state_nxt = IDLE;
            end
            CALC: begin
                // First CALC cycle is the RAM prefetch; crc_din_valid follows one cycle behind the read.
                if (rd_cnt != wr_cnt) begin
                    ram_re     = 1'b1;
                    cdv_nxt    = 1'b1;
                    rd_cnt_nxt = rd_cnt + ONE;
                end else begin
                    state_nxt = CAPT;
                end
            end
            CAPT: begin
                ram_re     = 1'b1;
                ram_addr   = '0;
                rd_cnt_nxt = '0;
                state_nxt  = DRAIN;
            end
            DRAIN: if (m_acc) begin
                ram_re     = 1'b1;
                ram_addr   = rd_cnt[ADDR_W-1:0] + A_ONE;
                rd_cnt_nxt = rd_cnt + ONE;
                if (rd_cnt == wr_cnt - ONE) state_nxt = CRCW;
            end
            CRCW: if (m_acc) begin
                rd_cnt_nxt = '0;
                wr_cnt_nxt = '0;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
            crc_din_valid <= 1'b0;
            ovf_err       <= 1'b0;
            crc_reg       <= '0;
        end else begin
            state         <= state_nxt;
            wr_cnt        <= wr_cnt_nxt;
            rd_cnt        <= rd_cnt_nxt;
            crc_din_valid <= cdv_nxt;
            ovf_err       <= ovf_nxt;
            if (state == CAPT && crc_dout_valid) crc_reg <= crc_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= s_data;
    end

    // Read register only moves on an explicit read, so a stalled DRAIN beat stays put.
    always_ff @(posedge clk) begin
        if (rst)         ram_q <= '0;
        else if (ram_re) ram_q <= mem[ram_addr];
    end
endmodule

// File: tb/tb_crc_frame_seq.sv
// Bench for crc_frame_seq: two instances (ADDR_W 8 and 2), an engine stand-in per instance, and a queue-based output model.
module tb_crc_frame_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CRC_FINAL_XOR_EN
    localparam logic [31:0] FX = 32'hFFFFFFFF;
    localparam logic [31:0] ZERO_CRC = 32'h38FB2284;
`else
    localparam logic [31:0] FX = 32'h0;
    localparam logic [31:0] ZERO_CRC = 32'hC704DD7B;
`endif

    logic rst = 1'b1;
    logic sel = 1'b0;
    logic d_valid = 1'b0, d_last = 1'b0, d_ready = 1'b1;
    logic [31:0] d_data = '0;

    logic sv_a, sr_a, sl_a, mv_a, mr_a, ml_a, cdv_a, edv_a, ovf_a, bsy_a;
    logic sv_b, sr_b, sl_b, mv_b, mr_b, ml_b, cdv_b, edv_b, ovf_b, bsy_b;
    logic [31:0] sd_a, md_a, cd_a, ed_a, eacc_a, sd_b, md_b, cd_b, ed_b, eacc_b;

    assign sv_a = !sel && d_valid;
    assign sv_b = sel && d_valid;
    assign sd_a = d_data;
    assign sd_b = d_data;
    assign sl_a = d_last;
    assign sl_b = d_last;
    assign mr_a = sel ? 1'b1 : d_ready;
    assign mr_b = sel ? d_ready : 1'b1;

    wire        o_sr  = sel ? sr_b  : sr_a;
    wire        o_mv  = sel ? mv_b  : mv_a;
    wire        o_ml  = sel ? ml_b  : ml_a;
    wire [31:0] o_md  = sel ? md_b  : md_a;
    wire        o_cdv = sel ? cdv_b : cdv_a;
    wire [31:0] o_cd  = sel ? cd_b  : cd_a;
    wire        o_ovf = sel ? ovf_b : ovf_a;
    wire        o_bsy = sel ? bsy_b : bsy_a;
    wire        o_mr  = d_ready;

    crc_frame_seq #(.ADDR_W(8)) u_seq_a (
        .clk(clk), .rst(rst), .s_valid(sv_a), .s_ready(sr_a), .s_data(sd_a), .s_last(sl_a),
        .m_valid(mv_a), .m_ready(mr_a), .m_data(md_a), .m_last(ml_a),
        .crc_din_valid(cdv_a), .crc_din(cd_a), .crc_dout_valid(edv_a), .crc_dout(ed_a),
        .ovf_err(ovf_a), .busy(bsy_a));

    crc_frame_seq #(.ADDR_W(2)) u_seq_b (
        .clk(clk), .rst(rst), .s_valid(sv_b), .s_ready(sr_b), .s_data(sd_b), .s_last(sl_b),
        .m_valid(mv_b), .m_ready(mr_b), .m_data(md_b), .m_last(ml_b),
        .crc_din_valid(cdv_b), .crc_din(cd_b), .crc_dout_valid(edv_b), .crc_dout(ed_b),
        .ovf_err(ovf_b), .busy(bsy_b));

    // Bit-serial CRC-32, MSB first, no reflection, no final xor.
    function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] d);
        logic [31:0] r;
        logic fb;
        r = c;
        for (int i = 31; i >= 0; i--) begin
            fb = r[31] ^ d[i];
            r = {r[30:0], 1'b0};
            if (fb) r = r ^ 32'h04C11DB7;
        end
        return r;
    endfunction

    // Engine stand-in: registered result, re-seeds whenever din_valid is low.
    always @(posedge clk) begin
        if (rst) begin
            edv_a <= 1'b0; ed_a <= '0; eacc_a <= '1;
            edv_b <= 1'b0; ed_b <= '0; eacc_b <= '1;
        end else begin
            edv_a <= cdv_a;
            if (cdv_a) begin
                ed_a <= crc_word(eacc_a, cd_a);
                eacc_a <= crc_word(eacc_a, cd_a);
            end else eacc_a <= '1;
            edv_b <= cdv_b;
            if (cdv_b) begin
                ed_b <= crc_word(eacc_b, cd_b);
                eacc_b <= crc_word(eacc_b, cd_b);
            end else eacc_b <= '1;
        end
    end

    int vectors = 0, miscompares = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic flag(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    logic [32:0] exp_q[$];
    int lat_cyc[$], lat_n[$], calc_q[$];
    logic [31:0] fw[$];
    logic [31:0] last_crc = '0;
    int beats = 0, ovf_cnt = 0, run = 0;
    logic pv_v = 1'b0, pv_r = 1'b0;
    logic [31:0] pv_d = '0;

    always @(negedge clk) begin
        logic [32:0] e;
        int lc, ln;
        if (rst) begin
            pv_v = 1'b0;
            run = 0;
        end else begin
            if (pv_v && !pv_r) begin
                chk("hold_valid", o_mv, 1);
                chk("hold_data", o_md, pv_d);
            end
            if (o_mv && !pv_v) begin
                if (lat_cyc.size() == 0) flag("unexpected m_valid");
                else begin
                    lc = lat_cyc.pop_front();
                    ln = lat_n.pop_front();
                    chk("first_m_valid_latency", cyc - lc, ln + 3);
                end
            end
            if (o_mv && o_mr) begin
                if (exp_q.size() == 0) flag("extra output beat");
                else begin
                    e = exp_q.pop_front();
                    chk("m_data", o_md, e[31:0]);
                    chk("m_last", o_ml, e[32]);
                    if (o_ml) last_crc = o_md;
                    beats++;
                end
            end
            if (o_cdv) run++;
            else if (run > 0) begin
                if (calc_q.size() == 0) flag("unexpected crc_din_valid run");
                else chk("crc_din_valid_run", run, calc_q.pop_front());
                run = 0;
            end
            if (d_valid) chk("s_ready_while_busy_out", o_sr && (o_mv || o_cdv), 0);
            if (o_ovf) ovf_cnt++;
            pv_v = o_mv;
            pv_r = o_mr;
            pv_d = o_md;
        end
    end

    int k = 0;
    logic mr_mode = 1'b0;
    logic [3:0] pat = 4'b1001;
    initial forever begin
        @(posedge clk);
        #1;
        d_ready = mr_mode ? pat[3 - (k % 4)] : 1'b1;
        k++;
    end

    // Drives fw as one frame; on s_last acceptance loads the model unless the frame must drop.
    task automatic send(input bit drop, output int stalls);
        int n, t;
        logic [31:0] c;
        n = fw.size();
        c = 32'hFFFFFFFF;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            d_valid = 1'b1;
            d_data = fw[i];
            d_last = (i == n - 1);
            t = 0;
            @(negedge clk);
            while (!o_sr && t < 400) begin
                t++;
                stalls++;
                @(negedge clk);
            end
            if (!o_sr) begin
                flag("s_ready timeout");
                d_valid = 1'b0;
                return;
            end
            if (i == n - 1 && !drop) begin
                foreach (fw[j]) begin
                    exp_q.push_back({1'b0, fw[j]});
                    c = crc_word(c, fw[j]);
                end
                exp_q.push_back({1'b1, c ^ FX});
                lat_cyc.push_back(cyc);
                lat_n.push_back(n);
                calc_q.push_back(n);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        d_valid = 1'b0;
        d_last = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || o_bsy) && t < 2000) begin
            t++;
            @(negedge clk);
        end
        if (t >= 2000) flag("drain timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int st, b0, t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("s_ready_in_rst", o_sr, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_s_ready", o_sr, 1);
        chk("rst_m_valid", o_mv, 0);
        chk("rst_m_last", o_ml, 0);
        chk("rst_m_data", o_md, 0);
        chk("rst_crc_din_valid", o_cdv, 0);
        chk("rst_crc_din", o_cd, 0);
        chk("rst_ovf_err", o_ovf, 0);
        chk("rst_busy", o_bsy, 0);
        @(posedge clk); #1;

        fw = '{32'h0};
        send(0, st); idle(); wait_idle();
        chk("crc_1word_zero", last_crc, ZERO_CRC);

        b0 = beats;
        fw = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        send(0, st); idle(); wait_idle();
        chk("beats_4word", beats - b0, 5);

        mr_mode = 1'b1;
        b0 = beats;
        fw = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h01234567, 32'h89ABCDEF};
        send(0, st); idle(); wait_idle();
        chk("beats_4word_stalled", beats - b0, 5);
        mr_mode = 1'b0;

        fw = '{32'hAAAA0001, 32'hAAAA0002};
        send(0, st);
        fw = '{32'hBBBB0001, 32'hBBBB0002};
        send(0, st);
        chk("b_held_off", st > 0, 1);
        idle(); wait_idle();

        fw.delete();
        for (int i = 0; i < 8; i++) fw.push_back(32'h80000000 + i);
        send(0, st); idle();
        t = 0;
        @(negedge clk);
        while (!o_mv && t < 100) begin t++; @(negedge clk); end
        chk("drain_reached", o_mv, 1);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_q.delete(); lat_cyc.delete(); lat_n.delete(); calc_q.delete();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_m_valid", o_mv, 0);
        chk("midrst_busy", o_bsy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        fw = '{32'hDEADBEEF};
        send(0, st); idle(); wait_idle();
        chk("ovf_none_after_rst", ovf_cnt, 0);

        sel = 1'b1;
        ovf_cnt = 0;
        fw = '{32'hC0000001, 32'hC0000002, 32'hC0000003, 32'hC0000004};
        send(0, st); idle(); wait_idle();
        chk("ovf_none_full_frame", ovf_cnt, 0);
        fw = '{32'hD1, 32'hD2, 32'hD3, 32'hD4, 32'hD5};
        send(1, st); idle();
        chk("s_ready_drop5", st, 0);
        repeat (4) @(negedge clk);
        chk("ovf_pulse_5", ovf_cnt, 1);
        chk("busy_after_drop", o_bsy, 0);
        @(posedge clk); #1;
        fw = '{32'hE1, 32'hE2, 32'hE3, 32'hE4, 32'hE5, 32'hE6, 32'hE7};
        send(1, st); idle();
        chk("s_ready_drop7", st, 0);
        repeat (4) @(negedge clk);
        chk("ovf_pulse_7", ovf_cnt, 2);
        @(posedge clk); #1;
        fw = '{32'hF0F0F0F0, 32'h0F0F0F0F};
        send(0, st); idle(); wait_idle();
        chk("ovf_after_recovery", ovf_cnt, 2);

        chk("exp_q_empty", exp_q.size(), 0);
        chk("calc_q_empty", calc_q.size(), 0);
        chk("lat_q_empty", lat_cyc.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule
